dec38_walker: RTL and testbench

Registered 3-to-8 decoder. It is the receive-side counterpart of the 8-3 priority encoder and accepts the encoder's code/valid pair (y, h). A load strobe captures the pair into an 8-bit LED/one-hot output register. Optional sequencing modes walk the lit bit up or down toward the end of the bank at a programmable step rate, then signal completion. Sits between the encoder (or switches) and the board LED bank.

---
 rtl/dec38_walker.sv | 123 ++++++++++++
 tb/tb_dec38_walker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dec38_walker.sv
`default_nettype none
// ============================================================================
// Module      : dec38_walker
// Description : Registered 3-to-8 decoder. It can also walk the lit bit up or
//               down to the end of the bank and then pulse done.
// Revision    : 1.0 - initial release
// ============================================================================
module dec38_walker #(
    parameter int DIV   = 4,
    parameter int W_CNT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [2:0] y,
    input  logic       h,
    input  logic [1:0] mode,
    output logic [7:0] x,
    output logic       busy,
    output logic       done
);

    localparam logic [W_CNT-1:0] c_div_last = W_CNT'(DIV - 1);
    localparam logic [1:0]       c_mode_dir  = 2'b00;
    localparam logic [1:0]       c_mode_up   = 2'b01;
    localparam logic [1:0]       c_mode_down = 2'b10;
    localparam logic [1:0]       c_mode_fill = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        WALK = 2'd2
    } state_t;

    state_t           r_state, w_state;
    logic [7:0]       r_x, w_x;
    logic             r_done, w_done;
    logic [W_CNT-1:0] r_cnt, w_cnt;
    logic             r_dir, w_dir;   // 1 = walking down

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_x     <= 8'h00;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_x     <= w_x;
            r_done  <= w_done;
            r_cnt   <= w_cnt;
            r_dir   <= w_dir;
        end
    end

    always_comb begin
        w_state = r_state;
        w_x     = r_x;
        w_done  = 1'b0;
        w_cnt   = r_cnt;
        w_dir   = r_dir;

        if (!en) begin
            w_state = IDLE;
            w_x     = 8'h00;
            w_cnt   = '0;
            w_dir   = 1'b0;
        end else begin
            case (r_state)
                WALK: begin
                    if (r_cnt == c_div_last) begin
                        w_cnt = '0;
                        // Reaching the end bit costs one extra period to detect.
                        if ((r_dir && r_x[0]) || (!r_dir && r_x[7])) begin
                            w_state = SHOW;
                            w_done  = 1'b1;
                        end else if (r_dir) begin
                            w_x = r_x >> 1;
                        end else begin
                            w_x = r_x << 1;
                        end
                    end else begin
                        w_cnt = r_cnt + W_CNT'(1);
                    end
                end
                default: begin
                    if (load) begin
                        if (!h) begin
                            w_state = IDLE;
                            w_x     = 8'h00;
                        end else begin
                            case (mode)
                                c_mode_dir: begin
                                    w_state = SHOW;
                                    w_x     = 8'h01 << y;
                                end
                                c_mode_fill: begin
                                    w_state = SHOW;
                                    w_x     = (8'h02 << y) - 8'h01;
                                end
                                c_mode_up, c_mode_down: begin
                                    w_state = WALK;
                                    w_x     = 8'h01 << y;
                                    w_cnt   = '0;
                                    w_dir   = (mode == c_mode_down);
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign x    = r_x;
    assign busy = (r_state == WALK);
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dec38_walker.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec38_walker
// Description : Scoreboard bench for dec38_walker at DIV=4 and DIV=1, driven
//               by directed and random stimulus against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dec38_walker;

    typedef struct packed {
        logic [7:0] x;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en, load, h;
    logic [2:0] y;
    logic [1:0] mode;
    logic [7:0] x4, x1;
    logic       busy4, busy1, done4, done1;

    int checks = 0;
    int errors = 0;

    exp_t q4[$];
    exp_t q1[$];

    // Model state per instance: 0 -> DIV=4, 1 -> DIV=1
    int   m_div  [2] = '{4, 1};
    bit   m_walk [2];
    bit   m_down [2];
    int   m_y0   [2];
    int   m_k    [2];
    int   m_x    [2];
    bit   m_done [2];

    always #5 clk = ~clk;

    dec38_walker #(.DIV(4), .W_CNT(16)) dut4 (
        .clk(clk), .rst(rst), .en(en), .load(load), .y(y), .h(h), .mode(mode),
        .x(x4), .busy(busy4), .done(done4)
    );

    dec38_walker #(.DIV(1), .W_CNT(16)) dut1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .y(y), .h(h), .mode(mode),
        .x(x1), .busy(busy1), .done(done1)
    );

    // Walk position is derived from elapsed time since the load edge:
    // step count = k/DIV capped at N, finish when k reaches (N+1)*DIV.
    task automatic model_step(input int i, input bit r, input bit e, input bit l,
                              input int yy, input bit hh, input int mm);
        int n, steps, pos;
        m_done[i] = 1'b0;
        if (r || !e) begin
            m_walk[i] = 1'b0;
            m_x[i]    = 0;
        end else if (m_walk[i]) begin
            m_k[i] = m_k[i] + 1;
            n = m_down[i] ? m_y0[i] : 7 - m_y0[i];
            if (m_k[i] == (n + 1) * m_div[i]) begin
                m_walk[i] = 1'b0;
                m_done[i] = 1'b1;
            end else begin
                steps = m_k[i] / m_div[i];
                pos   = m_down[i] ? m_y0[i] - steps : m_y0[i] + steps;
                m_x[i] = 1 << pos;
            end
        end else if (l) begin
            if (!hh)            m_x[i] = 0;
            else if (mm == 0)   m_x[i] = 1 << yy;
            else if (mm == 3)   m_x[i] = (2 << yy) - 1;
            else begin
                m_walk[i] = 1'b1;
                m_down[i] = (mm == 2);
                m_y0[i]   = yy;
                m_k[i]    = 0;
                m_x[i]    = 1 << yy;
            end
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit l,
                         input int yy, input bit hh, input int mm);
        exp_t ex;
        rst  = r;
        en   = e;
        load = l;
        y    = 3'(yy);
        h    = hh;
        mode = 2'(mm);
        for (int i = 0; i < 2; i++) begin
            model_step(i, r, e, l, yy, hh, mm);
            ex.x    = 8'(m_x[i]);
            ex.busy = m_walk[i];
            ex.done = m_done[i];
            if (i == 0) q4.push_back(ex);
            else        q1.push_back(ex);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(0, 1, 0, $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 3));
    endtask

    // Monitor: compares every registered output word one step after each edge.
    initial begin
        exp_t ex;
        int   cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q4.size() > 0) begin
                ex = q4.pop_front();
                checks++;
                if ({x4, busy4, done4} !== ex) begin
                    errors++;
                    $display("FAIL div4_out cycle %0d: got x=%h busy=%b done=%b want x=%h busy=%b done=%b",
                             cyc, x4, busy4, done4, ex.x, ex.busy, ex.done);
                end
            end
            if (q1.size() > 0) begin
                ex = q1.pop_front();
                checks++;
                if ({x1, busy1, done1} !== ex) begin
                    errors++;
                    $display("FAIL div1_out cycle %0d: got x=%h busy=%b done=%b want x=%h busy=%b done=%b",
                             cyc, x1, busy1, done1, ex.x, ex.busy, ex.done);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b0; y = 3'd0; h = 1'b0; mode = 2'd0;
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);

        // Reset from a non-zero output, then en=0 aborting a walk
        drive(0, 1, 1, 4, 1, 0);
        idle(2);
        drive(1, 1, 0, 0, 0, 0);
        idle(2);
        drive(0, 1, 1, 1, 1, 1);
        idle(5);
        drive(0, 0, 1, 6, 1, 0);
        idle(30);

        // Direct decode of every code, then an invalid code
        for (int k = 0; k < 8; k++) drive(0, 1, 1, k, 1, 0);
        drive(0, 1, 1, 5, 0, 0);
        idle(2);

        // Fill patterns held for ten cycles each
        drive(0, 1, 1, 0, 1, 3); idle(10);
        drive(0, 1, 1, 3, 1, 3); idle(10);
        drive(0, 1, 1, 7, 1, 3); idle(10);

        // Walk up from 2, walk down from 3, walk down from the end bit
        drive(0, 1, 1, 2, 1, 1); idle(30);
        drive(0, 1, 1, 3, 1, 2); idle(20);
        drive(0, 1, 1, 0, 1, 2); idle(8);
        drive(0, 1, 1, 7, 1, 1); idle(8);

        // Load attempts while busy are dropped; later load takes effect
        drive(0, 1, 1, 0, 1, 1);
        idle(2);
        drive(0, 1, 1, 5, 1, 0);
        idle(35);
        drive(0, 1, 1, 5, 1, 0);
        idle(3);

        // Random traffic
        for (int k = 0; k < 800; k++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7),
                  $urandom_range(0, 7) != 0,
                  $urandom_range(0, 3));
        end

        @(posedge clk);
        #2;
        checks++;
        if (q4.size() + q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", q4.size() + q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
